// File: rtl/blank_splitter_pkg.sv
// Shared video-timing defaults and the blank classifier state encoding.
package blank_splitter_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int GLITCH_DEF      = 3;
  localparam int VTHRESH_DEF     = 1024;
  localparam int CW_DEF          = 13;
  localparam int LW_DEF          = 10;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HBLK   = 2'd1,
    VBLK   = 2'd2
  } blank_state_e;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/blank_deglitch.sv
// Brings the asynchronous host blank into the CLK domain and suppresses
// pulses shorter than GLITCH cycles.
module blank_deglitch
  import blank_splitter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GLITCH      = GLITCH_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic nBLANK_IN,
  output logic filt
);

  localparam int GW = cntWidth(GLITCH);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [GW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_s;

  assign w_s  = r_sync[SYNC_STAGES-1];
  assign filt = r_filt;

  // The filtered level only follows s after GLITCH consecutive disagreeing cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '1;
      r_cnt  <= '0;
      r_filt <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], nBLANK_IN};
      if (w_s != r_filt) begin
        if (r_cnt == GW'(GLITCH - 1)) begin
          r_filt <= w_s;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + GW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/blank_splitter.sv
// Splits the deglitched host blank into horizontal and vertical blanks by
// duration, and reports line length and lines-per-frame.
module blank_splitter
  import blank_splitter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int GLITCH      = GLITCH_DEF,
  parameter int VTHRESH     = VTHRESH_DEF,
  parameter int CW          = CW_DEF,
  parameter int LW          = LW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          nBLANK_IN,
  output logic          nBLANK_OUT,
  output logic          nHBLANK,
  output logic          nVBLANK,
  output logic [CW-1:0] HB_LEN,
  output logic [LW-1:0] LINES,
  output logic          FRAME
);

  logic w_filt;

  blank_deglitch #(
    .SYNC_STAGES(SYNC_STAGES),
    .GLITCH     (GLITCH)
  ) u_deglitch (
    .CLK      (CLK),
    .RST      (RST),
    .nBLANK_IN(nBLANK_IN),
    .filt     (w_filt)
  );

  blank_state_e  r_state, w_stateNext;
  logic [CW-1:0] r_dur, w_durNext;
  logic [LW-1:0] r_lineCnt, w_lineCntNext;
  logic [CW-1:0] r_hbLen, w_hbLenNext;
  logic [LW-1:0] r_lines, w_linesNext;
  logic          r_nH, w_nHNext;
  logic          r_nV, w_nVNext;
  logic          r_frame, w_frameNext;

  assign nBLANK_OUT = w_filt;
  assign nHBLANK    = r_nH;
  assign nVBLANK    = r_nV;
  assign HB_LEN     = r_hbLen;
  assign LINES      = r_lines;
  assign FRAME      = r_frame;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ACTIVE;
      r_dur     <= '0;
      r_lineCnt <= '0;
      r_hbLen   <= '0;
      r_lines   <= '0;
      r_nH      <= 1'b1;
      r_nV      <= 1'b1;
      r_frame   <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_dur     <= w_durNext;
      r_lineCnt <= w_lineCntNext;
      r_hbLen   <= w_hbLenNext;
      r_lines   <= w_linesNext;
      r_nH      <= w_nHNext;
      r_nV      <= w_nVNext;
      r_frame   <= w_frameNext;
    end
  end

  // A rising filt is tested before the threshold so a simultaneous end stays horizontal.
  always_comb begin
    w_stateNext   = r_state;
    w_durNext     = r_dur;
    w_lineCntNext = r_lineCnt;
    w_hbLenNext   = r_hbLen;
    w_linesNext   = r_lines;
    w_nHNext      = r_nH;
    w_nVNext      = r_nV;
    w_frameNext   = 1'b0;
    unique case (r_state)
      ACTIVE: begin
        w_durNext = '0;
        if (!w_filt) begin
          w_stateNext = HBLK;
          w_nHNext    = 1'b0;
          w_durNext   = CW'(1);
        end
      end
      HBLK: begin
        if (w_filt) begin
          w_stateNext = ACTIVE;
          w_nHNext    = 1'b1;
          w_hbLenNext = r_dur;
          w_durNext   = '0;
          if (r_lineCnt != '1) w_lineCntNext = r_lineCnt + LW'(1);
        end else begin
          w_durNext = r_dur + CW'(1);
          if (r_dur == CW'(VTHRESH - 1)) begin
            w_stateNext = VBLK;
            w_nHNext    = 1'b1;
            w_nVNext    = 1'b0;
          end
        end
      end
      VBLK: begin
        if (w_filt) begin
          w_stateNext   = ACTIVE;
          w_nVNext      = 1'b1;
          w_linesNext   = r_lineCnt;
          w_lineCntNext = '0;
          w_frameNext   = 1'b1;
          w_durNext     = '0;
        end else if (r_dur != '1) begin
          w_durNext = r_dur + CW'(1);
        end
      end
      default: begin
        w_stateNext = ACTIVE;
        w_nHNext    = 1'b1;
        w_nVNext    = 1'b1;
        w_durNext   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_blank_splitter.sv
// Self-checking bench for blank_splitter: directed table, hand sequences for
// reset/frame corners, and a randomized run against a run-length model.
module tb_blank_splitter;

  localparam int SS  = 2;
  localparam int GL  = 3;
  localparam int VT  = 64;
  localparam int CW  = 13;
  localparam int LW  = 10;
  localparam int LAT = SS + GL;

  typedef struct {
    int lowLen;
    int highLen;
    int expOut;
    int expH;
    int expV;
    int expHb;
    int expLines;
    int expFrames;
  } vec_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic          nBLANK_IN;
  logic          nBLANK_OUT;
  logic          nHBLANK;
  logic          nVBLANK;
  logic [CW-1:0] HB_LEN;
  logic [LW-1:0] LINES;
  logic          FRAME;

  blank_splitter #(
    .SYNC_STAGES(SS),
    .GLITCH     (GL),
    .VTHRESH    (VT),
    .CW         (CW),
    .LW         (LW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .nBLANK_IN (nBLANK_IN),
    .nBLANK_OUT(nBLANK_OUT),
    .nHBLANK   (nHBLANK),
    .nVBLANK   (nVBLANK),
    .HB_LEN    (HB_LEN),
    .LINES     (LINES),
    .FRAME     (FRAME)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFails  = 0;
  int cntOut, cntH, cntV, cntFrame;

  // Reference model state for the randomized run
  logic mPipe[$];
  int   mRun, mLastRun, mHb, mLines, mAcc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut(input logic lvl);
    nBLANK_IN = lvl;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic clearCounts();
    cntOut = 0; cntH = 0; cntV = 0; cntFrame = 0;
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      nBLANK_IN = lvl;
      tick();
      if (!nBLANK_OUT) cntOut++;
      if (!nHBLANK) cntH++;
      if (!nVBLANK) cntV++;
      if (FRAME) cntFrame++;
      checkOutput("hv_exclusive", 32'(nHBLANK | nVBLANK), 32'd1);
    end
  endtask

  task automatic modelCycle(input logic stimV, input logic idealV);
    logic d;
    logic expFrame;
    nBLANK_IN = stimV;
    tick();
    mPipe.push_back(idealV);
    d = mPipe.pop_front();
    expFrame = 1'b0;
    if (mRun == 0 && mLastRun > 0) begin
      if (mLastRun < VT) begin
        mHb = mLastRun;
        if (mAcc < (2**LW) - 1) mAcc++;
      end else begin
        mLines = mAcc;
        mAcc = 0;
        expFrame = 1'b1;
      end
    end
    checkOutput("rnd_nblank_out", 32'(nBLANK_OUT), 32'(d));
    checkOutput("rnd_nhblank", 32'(nHBLANK), 32'(!(mRun >= 1 && mRun <= VT - 1)));
    checkOutput("rnd_nvblank", 32'(nVBLANK), 32'(!(mRun >= VT)));
    checkOutput("rnd_hb_len", 32'(HB_LEN), 32'(mHb));
    checkOutput("rnd_lines", 32'(LINES), 32'(mLines));
    checkOutput("rnd_frame", 32'(FRAME), 32'(expFrame));
    mLastRun = mRun;
    mRun = d ? 0 : mRun + 1;
  endtask

  initial begin
    vec_t vecs[7];
    int   total, len, gStart, gLen, r;
    logic lvl, s;

    vecs = '{
      '{2,   20, 0,   0,  0,   0,  0, 0},
      '{3,   20, 3,   3,  0,   3,  0, 0},
      '{40,  20, 40,  40, 0,   40, 0, 0},
      '{63,  20, 63,  63, 0,   63, 0, 0},
      '{64,  20, 64,  63, 1,   63, 3, 1},
      '{40,  20, 40,  40, 0,   40, 3, 0},
      '{500, 20, 500, 63, 437, 40, 1, 1}
    };

    // Reset with blank asserted, then exact pipeline latency after release
    resetDut(1'b0);
    checkOutput("rst_nblank_out", 32'(nBLANK_OUT), 32'd1);
    checkOutput("rst_nhblank", 32'(nHBLANK), 32'd1);
    checkOutput("rst_nvblank", 32'(nVBLANK), 32'd1);
    checkOutput("rst_hb_len", 32'(HB_LEN), 32'd0);
    checkOutput("rst_lines", 32'(LINES), 32'd0);
    checkOutput("rst_frame", 32'(FRAME), 32'd0);
    for (int e = 1; e <= LAT + 1; e++) begin
      tick();
      checkOutput($sformatf("lat_nblank_out_e%0d", e), 32'(nBLANK_OUT), 32'(e < LAT));
      checkOutput($sformatf("lat_nhblank_e%0d", e), 32'(nHBLANK), 32'(e < LAT + 1));
    end
    applyStimulus(1'b0, 10);
    applyStimulus(1'b1, 20);

    // Directed blank lengths around the glitch and vertical thresholds
    resetDut(1'b1);
    for (int v = 0; v < 7; v++) begin
      clearCounts();
      applyStimulus(1'b0, vecs[v].lowLen);
      applyStimulus(1'b1, vecs[v].highLen);
      checkOutput($sformatf("vec%0d_out_low", v), 32'(cntOut), 32'(vecs[v].expOut));
      checkOutput($sformatf("vec%0d_h_low", v), 32'(cntH), 32'(vecs[v].expH));
      checkOutput($sformatf("vec%0d_v_low", v), 32'(cntV), 32'(vecs[v].expV));
      checkOutput($sformatf("vec%0d_hb_len", v), 32'(HB_LEN), 32'(vecs[v].expHb));
      checkOutput($sformatf("vec%0d_lines", v), 32'(LINES), 32'(vecs[v].expLines));
      checkOutput($sformatf("vec%0d_frames", v), 32'(cntFrame), 32'(vecs[v].expFrames));
    end

    // Full frame of 200 lines, then a short frame to show the count restarts
    clearCounts();
    for (int l = 0; l < 200; l++) begin
      applyStimulus(1'b0, 40);
      applyStimulus(1'b1, 10);
    end
    applyStimulus(1'b0, 500);
    applyStimulus(1'b1, 20);
    checkOutput("frame_pulses", 32'(cntFrame), 32'd1);
    checkOutput("frame_lines", 32'(LINES), 32'd200);
    checkOutput("frame_hb_len", 32'(HB_LEN), 32'd40);
    clearCounts();
    for (int l = 0; l < 3; l++) begin
      applyStimulus(1'b0, 40);
      applyStimulus(1'b1, 10);
    end
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 20);
    checkOutput("frame2_pulses", 32'(cntFrame), 32'd1);
    checkOutput("frame2_lines", 32'(LINES), 32'd3);

    // Reset in the middle of a vertical blank abandons it
    applyStimulus(1'b0, 40);
    applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 100);
    checkOutput("mid_in_vblank", 32'(nVBLANK), 32'd0);
    nBLANK_IN = 1'b1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkOutput("mid_rst_nvblank", 32'(nVBLANK), 32'd1);
    checkOutput("mid_rst_lines", 32'(LINES), 32'd0);
    checkOutput("mid_rst_frame", 32'(FRAME), 32'd0);
    clearCounts();
    applyStimulus(1'b1, 20);
    checkOutput("mid_after_frames", 32'(cntFrame), 32'd0);
    checkOutput("mid_after_v_low", 32'(cntV), 32'd0);
    checkOutput("mid_after_lines", 32'(LINES), 32'd0);

    // Randomized blanks, some with absorbed glitches, against the run-length model
    resetDut(1'b1);
    mPipe = {};
    repeat (LAT - 1) mPipe.push_back(1'b1);
    mRun = 0; mLastRun = 0; mHb = 0; mLines = 0; mAcc = 0;
    total = 0;
    lvl = 1'b0;
    while (total < 4000) begin
      if (!lvl) begin
        r = int'($urandom_range(0, 9));
        if (r < 6) len = int'($urandom_range(3, 70));
        else if (r < 8) len = int'($urandom_range(VT - 2, VT + 1));
        else len = int'($urandom_range(VT, 200));
      end else begin
        len = int'($urandom_range(3, 25));
      end
      gStart = -1;
      gLen = 0;
      if (len >= 8 && $urandom_range(0, 3) == 0) begin
        gLen = int'($urandom_range(1, GL - 1));
        gStart = int'($urandom_range(3, len - gLen - 3));
      end
      for (int i = 0; i < len; i++) begin
        s = (i >= gStart && i < gStart + gLen) ? !lvl : lvl;
        modelCycle(s, lvl);
      end
      total += len;
      lvl = !lvl;
    end
    for (int i = 0; i < 20; i++) modelCycle(1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/blank_splitter.md
Name: blank_splitter

Overview:
- Conditions the host nBLANK before it reaches the sync generators.
- Synchronises the asynchronous host blank into the 16 MHz domain and rejects glitches.
- Classifies each blank interval as horizontal or vertical by its duration.
- Drives separate nHBLANK/nVBLANK to the downstream HSYNC/VSYNC generators, plus line-count and timing status for the GVRAM controller.

Parameters:
SYNC_STAGES, 2, flip-flop stages in the input synchroniser (minimum 2).
GLITCH, 3, consecutive stable cycles required before the filtered level changes (minimum 1).
VTHRESH, 1024, low-duration in cycles at which a blank is reclassified as vertical.
CW, 13, width of the blank-duration counter; VTHRESH < 2^CW.
LW, 10, width of the line counter.

Ports:
CLK  in  1  16 MHz system clock; every flop is on its rising edge.
RST  in  1  Synchronous, active-high reset.
nBLANK_IN  in  1  Raw host blank, asynchronous, low = blanking.
nBLANK_OUT  out  1  Synchronised, deglitched blank, low = blanking.
nHBLANK  out  1  Low while the current blank is classified horizontal.
nVBLANK  out  1  Low while the current blank is classified vertical.
HB_LEN  out  CW  Low-duration in cycles of the last completed horizontal blank.
LINES  out  LW  Horizontal blanks completed in the last frame.
FRAME  out  1  One-cycle pulse on the cycle vertical blank ends.

Behaviour:
- Reset (synchronous, RST high at an edge) gives:
  - synchroniser flops = 1, filtered level = 1, glitch counter = 0, state ACTIVE;
  - nBLANK_OUT = nHBLANK = nVBLANK = 1;
  - HB_LEN = 0, LINES = 0, FRAME = 0;
  - duration and line counters = 0.
- Reset takes priority over all other events. Reset mid-blank abandons the interval; nothing is latched.
- Synchroniser: SYNC_STAGES-flop shift register; s = last stage.
- Deglitch filter:
  - the glitch counter increments while s != filt and clears when s == filt;
  - when s != filt and the counter == GLITCH-1, filt <= s and the counter clears;
  - pulses shorter than GLITCH cycles at s never change filt;
  - latency: a clean input change appears on nBLANK_OUT exactly SYNC_STAGES+GLITCH edges after the first edge that samples it.
- nBLANK_OUT = filt, registered.
- State machine, evaluated on filt (one registered cycle later than nBLANK_OUT):
  - ACTIVE: duration counter = 0.
    - filt falls -> HBLK; nHBLANK <= 0; duration <= 1.
  - HBLK: duration increments.
    - filt rises -> ACTIVE; nHBLANK <= 1; HB_LEN <= duration; line counter +1, saturating at 2^LW-1.
    - duration == VTHRESH-1 with filt still low -> VBLK; nHBLANK <= 1, nVBLANK <= 0.
  - VBLK: duration increments, saturating at 2^CW-1; no wrap.
    - filt rises -> ACTIVE; nVBLANK <= 1; LINES <= line counter; line counter <= 0; FRAME <= 1 for that one cycle.
- Boundary rule: a blank lasting exactly VTHRESH-1 filtered cycles stays horizontal; one lasting VTHRESH cycles becomes vertical.
- nHBLANK and nVBLANK are never low together.
- A horizontal blank that escalates to vertical is not counted as a line and does not update HB_LEN.
- The first LINES value after reset reflects a partial frame. This is accepted.
- Simultaneous rise of filt and the VTHRESH crossing: the rise wins; the blank stays horizontal.

Decomposition:
- The shared video package holds SYNC_STAGES, GLITCH, VTHRESH and CW defaults, and the state encoding (ACTIVE/HBLK/VBLK).
- One sub-module is natural: blank_deglitch (synchroniser plus filter). Its ports are CLK, RST, nBLANK_IN, filt.
- The classifier stays in blank_splitter.

Test Plan (bench parameters GLITCH=3, VTHRESH=64, SYNC_STAGES=2):
- Reset: RST high 2 cycles with nBLANK_IN=0 -> all outputs 1/0 as listed in Behaviour; after release, nBLANK_OUT falls exactly 5 edges after the first sampling edge.
- Glitch rejection: nBLANK_IN low for 2 cycles, then high -> nBLANK_OUT, nHBLANK and nVBLANK stay 1. A 3-cycle low -> nBLANK_OUT low for 3 cycles.
- Horizontal blank of 40 cycles -> nHBLANK low 40 cycles, nVBLANK stays 1, HB_LEN=40, line counter +1.
- Threshold boundary:
  - 63-cycle blank -> horizontal, HB_LEN=63;
  - 64-cycle blank -> nHBLANK low 63 cycles then nVBLANK low; HB_LEN unchanged.
- Frame: 200 blanks of 40 cycles, then a 500-cycle blank -> FRAME pulses once at vertical-blank end, LINES=200, next frame counts from 0.
- Reset mid-vertical-blank at cycle 100 -> nVBLANK=1 on the next cycle, no FRAME pulse, LINES=0.
